game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 28 ++
 rtl/game_sequencer_if.sv | 44 ++++
 rtl/sec_prescaler.sv | 32 +++
 rtl/game_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the game top, the game sequencer and the HUD renderer.
//   STATE_W / ST_*  : game-flow state codes as they appear on the sequencer's state output
//   SPEED_W         : width of the speed level bus
//   LIVES_W         : width of the lives counter
//   game_state_e    : enumerated FSM state built on the codes above
package game_pkg;

  localparam int SPEED_W = 3;
  localparam int LIVES_W = 2;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_COUNTDOWN = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd2;
  localparam logic [STATE_W-1:0] ST_CRASH     = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER      = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAUSE     = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_COUNTDOWN = ST_COUNTDOWN,
    S_RUN       = ST_RUN,
    S_CRASH     = ST_CRASH,
    S_OVER      = ST_OVER,
    S_PAUSE     = ST_PAUSE
  } game_state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: pad inputs and game-flow outputs of the game sequencer.
//   master : the sequencer (consumes pad/collision inputs, drives flow outputs)
//   slave  : the surrounding logic (pad debounce, road engine, HUD)
// pause_n exists only when GAME_SEQ_PAUSE_EN is defined.
interface game_sequencer_if;
  import game_pkg::*;

  logic               start_n;
`ifdef GAME_SEQ_PAUSE_EN
  logic               pause_n;
`endif
  logic               colision;
  logic [STATE_W-1:0] state;
  logic               alive;
  logic               drop_en;
  logic               accel_tick;
  logic [SPEED_W-1:0] speed_level;
  logic [LIVES_W-1:0] lives;
  logic [1:0]         countdown;
  logic               score_tick;
  logic               clear_obstacles;
  logic               game_over;

  modport master (
    input  start_n,
`ifdef GAME_SEQ_PAUSE_EN
    input  pause_n,
`endif
    input  colision,
    output state, alive, drop_en, accel_tick, speed_level, lives,
    output countdown, score_tick, clear_obstacles, game_over
  );

  modport slave (
    output start_n,
`ifdef GAME_SEQ_PAUSE_EN
    output pause_n,
`endif
    output colision,
    input  state, alive, drop_en, accel_tick, speed_level, lives,
    input  countdown, score_tick, clear_obstacles, game_over
  );

endinterface

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides the system clock down to one game second.
//   clk  in  : system clock
//   en   in  : advance the count this cycle
//   clr  in  : force the count to 0 (wins over en)
//   tick out : high while the count sits on its last value (SEC_CYCLES-1)
// tick is not gated by en so the owner can freeze the count on a pending
// second and still see that second once it resumes.
module sec_prescaler #(
  parameter int SEC_CYCLES = 50000000
) (
  input  logic clk,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SEC_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller (attract, countdown, run, crash, game over).
//   clk    in : system clock
//   reset2 in : synchronous active-low reset
//   bus       : game_sequencer_if.master
//     start_n, colision (and pause_n) in; state, alive, drop_en, accel_tick,
//     speed_level, lives, countdown, score_tick, clear_obstacles, game_over out
// Optional build macro: GAME_SEQ_PAUSE_EN adds pause_n and the PAUSE state.
// Every output is a register or a decode of the state register.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SEC_CYCLES    = 50000000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int CRASH_SEC     = 2,
  parameter int ACCEL_SEC     = 8,
  parameter int LIVES         = 3,
  parameter int MAX_LEVEL     = 7
) (
  input logic              clk,
  input logic              reset2,
  game_sequencer_if.master bus
);

  localparam int ACC_W = (ACCEL_SEC > 1) ? $clog2(ACCEL_SEC) : 1;
  localparam int CRS_W = (CRASH_SEC > 1) ? $clog2(CRASH_SEC) : 1;

  game_state_e        state_q, state_d;
  logic [1:0]         countdown_q, countdown_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [ACC_W-1:0]   accel_q, accel_d;
  logic [CRS_W-1:0]   crash_q, crash_d;
  logic               score_q, score_d;
  logic               acc_tick_q, acc_tick_d;
  logic               clr_obs_q, clr_obs_d;
  // Button level is kept active-high; its reset value of 1 means a button
  // held through reset must be released before it can produce a press.
  logic               start_lvl_q, start_press_q;
`ifdef GAME_SEQ_PAUSE_EN
  logic               pause_lvl_q, pause_press_q;
`endif
  logic               sec_tick, pre_en, pre_clr, pause_move;

  // Second prescaler: frozen across RUN<->PAUSE, cleared on other changes
  assign pause_move = (state_q == S_PAUSE) || (state_d == S_PAUSE);
  assign pre_en  = (state_d == state_q) &&
                   ((state_q == S_COUNTDOWN) || (state_q == S_RUN) || (state_q == S_CRASH));
  assign pre_clr = !reset2 || (state_q == S_IDLE) || (state_q == S_OVER) ||
                   ((state_d != state_q) && !pause_move);

  sec_prescaler #(.SEC_CYCLES(SEC_CYCLES)) u_prescaler (
    .clk  (clk),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (sec_tick)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    lives_d     = lives_q;
    speed_d     = speed_q;
    accel_d     = accel_q;
    crash_d     = crash_q;
    score_d     = 1'b0;
    acc_tick_d  = 1'b0;
    clr_obs_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_press_q) begin
          state_d     = S_COUNTDOWN;
          lives_d     = LIVES_W'(LIVES);
          speed_d     = '0;
          accel_d     = '0;
          countdown_d = 2'(COUNTDOWN_SEC);
          clr_obs_d   = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (sec_tick) begin
          if (countdown_q <= 2'd1) begin
            state_d     = S_RUN;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end
      end
      S_RUN: begin
        // Collision beats a pause press and the pending second
        if (bus.colision) begin
          state_d = S_CRASH;
          lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
          speed_d = '0;
          accel_d = '0;
          crash_d = '0;
`ifdef GAME_SEQ_PAUSE_EN
        end else if (pause_press_q) begin
          state_d = S_PAUSE;
`endif
        end else if (sec_tick) begin
          score_d = 1'b1;
          if (accel_q == ACC_W'(ACCEL_SEC - 1)) begin
            accel_d = '0;
            if (speed_q < SPEED_W'(MAX_LEVEL)) begin
              speed_d    = speed_q + SPEED_W'(1);
              acc_tick_d = 1'b1;
            end
          end else begin
            accel_d = accel_q + ACC_W'(1);
          end
        end
      end
      S_CRASH: begin
        if (sec_tick) begin
          if (crash_q == CRS_W'(CRASH_SEC - 1)) begin
            if (lives_q == '0) begin
              state_d = S_OVER;
            end else begin
              state_d     = S_COUNTDOWN;
              countdown_d = 2'(COUNTDOWN_SEC);
              clr_obs_d   = 1'b1;
            end
          end else begin
            crash_d = crash_q + CRS_W'(1);
          end
        end
      end
      S_PAUSE: begin
`ifdef GAME_SEQ_PAUSE_EN
        if (pause_press_q) begin
          state_d = S_RUN;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset2) begin
      state_q       <= S_IDLE;
      countdown_q   <= '0;
      lives_q       <= LIVES_W'(LIVES);
      speed_q       <= '0;
      accel_q       <= '0;
      crash_q       <= '0;
      score_q       <= 1'b0;
      acc_tick_q    <= 1'b0;
      clr_obs_q     <= 1'b0;
      start_lvl_q   <= 1'b1;
      start_press_q <= 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      pause_lvl_q   <= 1'b1;
      pause_press_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      countdown_q   <= countdown_d;
      lives_q       <= lives_d;
      speed_q       <= speed_d;
      accel_q       <= accel_d;
      crash_q       <= crash_d;
      score_q       <= score_d;
      acc_tick_q    <= acc_tick_d;
      clr_obs_q     <= clr_obs_d;
      start_lvl_q   <= ~bus.start_n;
      start_press_q <= ~start_lvl_q & ~bus.start_n;
`ifdef GAME_SEQ_PAUSE_EN
      pause_lvl_q   <= ~bus.pause_n;
      pause_press_q <= ~pause_lvl_q & ~bus.pause_n;
`endif
    end
  end

  assign bus.state           = state_q;
  assign bus.alive           = (state_q == S_RUN);
  assign bus.drop_en         = (state_q == S_RUN);
  assign bus.game_over       = (state_q == S_OVER);
  assign bus.accel_tick      = acc_tick_q;
  assign bus.speed_level     = speed_q;
  assign bus.lives           = lives_q;
  assign bus.countdown       = countdown_q;
  assign bus.score_tick      = score_q;
  assign bus.clear_obstacles = clr_obs_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed game-flow scenarios plus randomized pad/collision
// traffic, compared every cycle against a second-by-second model of the game.
module tb_game_sequencer;

  localparam int SEC  = 4;
  localparam int CDS  = 3;
  localparam int CRS  = 2;
  localparam int ACC  = 2;
  localparam int LIV  = 2;
  localparam int MAXL = 2;

  localparam int P_IDLE = 0, P_CD = 1, P_RUN = 2, P_CRASH = 3, P_OVER = 4, P_PAUSE = 5;

  logic clk = 1'b0;
  logic reset2;
  int   n_checks = 0;
  int   n_errors = 0;

  game_sequencer_if bus();

  game_sequencer #(
    .SEC_CYCLES(SEC), .COUNTDOWN_SEC(CDS), .CRASH_SEC(CRS),
    .ACCEL_SEC(ACC), .LIVES(LIV), .MAX_LEVEL(MAXL)
  ) dut (
    .clk    (clk),
    .reset2 (reset2),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Game model: phase, position inside the current second, seconds counted
  int m_state, m_pos, m_cd, m_lives, m_lvl, m_run_secs, m_crash_secs;
  bit m_score, m_acc, m_clr;
  bit m_btn, m_press, m_pbtn, m_ppress;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predicts the block after the coming rising edge from the inputs now applied.
  task automatic model_step();
    int  nxt;
    bit  tick, pn;
`ifdef GAME_SEQ_PAUSE_EN
    pn = bus.pause_n;
`else
    pn = 1'b1;
`endif
    if (reset2 == 1'b0) begin
      m_state = P_IDLE; m_pos = 0; m_cd = 0; m_lives = LIV; m_lvl = 0;
      m_run_secs = 0; m_crash_secs = 0; m_score = 0; m_acc = 0; m_clr = 0;
      m_btn = 1; m_press = 0; m_pbtn = 1; m_ppress = 0;
      return;
    end
    tick = (m_pos == SEC - 1);
    nxt = m_state;
    m_score = 0; m_acc = 0; m_clr = 0;
    if (m_state == P_IDLE || m_state == P_OVER) begin
      if (m_press) begin
        nxt = P_CD; m_lives = LIV; m_lvl = 0; m_run_secs = 0; m_cd = CDS; m_clr = 1;
      end
    end else if (m_state == P_CD) begin
      if (tick) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) nxt = P_RUN;
      end
    end else if (m_state == P_RUN) begin
      if (bus.colision) begin
        nxt = P_CRASH;
        if (m_lives > 0) m_lives = m_lives - 1;
        m_lvl = 0; m_run_secs = 0; m_crash_secs = 0;
      end else if (m_ppress) begin
        nxt = P_PAUSE;
      end else if (tick) begin
        m_score = 1;
        m_run_secs = m_run_secs + 1;
        if (m_run_secs == ACC) begin
          m_run_secs = 0;
          if (m_lvl < MAXL) begin
            m_lvl = m_lvl + 1; m_acc = 1;
          end
        end
      end
    end else if (m_state == P_PAUSE) begin
      if (m_ppress) nxt = P_RUN;
    end else if (m_state == P_CRASH) begin
      if (tick) begin
        m_crash_secs = m_crash_secs + 1;
        if (m_crash_secs == CRS) begin
          if (m_lives == 0) nxt = P_OVER;
          else begin
            nxt = P_CD; m_cd = CDS; m_clr = 1;
          end
        end
      end
    end
    if (nxt != m_state) begin
      if (nxt != P_PAUSE && m_state != P_PAUSE) m_pos = 0;
    end else if (m_state == P_CD || m_state == P_RUN || m_state == P_CRASH) begin
      m_pos = (m_pos + 1) % SEC;
    end else if (m_state != P_PAUSE) begin
      m_pos = 0;
    end
    m_state = nxt;
    m_press  = !m_btn && !bus.start_n;
    m_btn    = !bus.start_n;
    m_ppress = !m_pbtn && !pn;
    m_pbtn   = !pn;
  endtask

  task automatic compare();
    check("state",     int'(bus.state), m_state);
    check("alive",     int'(bus.alive), int'(m_state == P_RUN));
    check("drop_en",   int'(bus.drop_en), int'(m_state == P_RUN));
    check("game_over", int'(bus.game_over), int'(m_state == P_OVER));
    check("countdown", int'(bus.countdown), m_cd);
    check("lives",     int'(bus.lives), m_lives);
    check("speed",     int'(bus.speed_level), m_lvl);
    check("score_tk",  int'(bus.score_tick), int'(m_score));
    check("accel_tk",  int'(bus.accel_tick), int'(m_acc));
    check("clr_obs",   int'(bus.clear_obstacles), int'(m_clr));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run_until(input string tag, input int want, input int limit, output int n);
    n = 0;
    while (int'(bus.state) != want && n < limit) begin
      cycle();
      n++;
    end
    if (int'(bus.state) != want) check(tag, int'(bus.state), want);
  endtask

  task automatic press_start();
    bus.start_n = 1'b0;
    cycle();
    bus.start_n = 1'b1;
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nscore, nacc, nclr;
    reset2 = 1'b0;
    bus.start_n = 1'b1;
    bus.colision = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    bus.pause_n = 1'b1;
`endif
    repeat (3) cycle();
    check("rst_state", int'(bus.state), P_IDLE);
    check("rst_lives", int'(bus.lives), LIV);
    reset2 = 1'b1;
    repeat (2) cycle();

    // Start press and countdown
    nclr = 0;
    bus.start_n = 1'b0;
    cycle();
    check("start_early", int'(bus.state), P_IDLE);
    bus.start_n = 1'b1;
    cycle();
    check("start_lat", int'(bus.state), P_CD);
    check("cd_load", int'(bus.countdown), CDS);
    nclr += int'(bus.clear_obstacles);
    n = 0;
    while (int'(bus.state) != P_RUN && n < 30) begin
      cycle();
      n++;
      nclr += int'(bus.clear_obstacles);
    end
    check("cd_len", n, CDS * SEC);
    check("clr_pulses", nclr, 1);

    // 40 cycles of running: score every second, level steps at seconds 2 and 4
    nscore = 0; nacc = 0;
    repeat (40) begin
      cycle();
      nscore += int'(bus.score_tick);
      nacc   += int'(bus.accel_tick);
    end
    check("score_cnt", nscore, 10);
    check("accel_cnt", nacc, 2);
    check("speed_sat", int'(bus.speed_level), MAXL);

    // Collision on a second boundary
    for (int i = 0; i < SEC && m_pos != SEC - 1; i++) cycle();
    bus.colision = 1'b1;
    cycle();
    bus.colision = 1'b0;
    check("crash_state", int'(bus.state), P_CRASH);
    check("crash_score", int'(bus.score_tick), 0);
    check("crash_lives", int'(bus.lives), LIV - 1);
    check("crash_speed", int'(bus.speed_level), 0);
    run_until("tmo_crash1", P_CD, 20, n);
    check("crash_len", n, CRS * SEC);

    // Second crash ends the game
    run_until("tmo_run2", P_RUN, 30, n);
    repeat ($urandom_range(0, 9)) cycle();
    bus.colision = 1'b1;
    cycle();
    bus.colision = 1'b0;
    run_until("tmo_over", P_OVER, 20, n);
    check("over_len", n, CRS * SEC);
    check("over_flag", int'(bus.game_over), 1);
    check("over_lives", int'(bus.lives), 0);
    cycle();
    press_start();
    check("restart", int'(bus.state), P_CD);
    check("restart_lv", int'(bus.lives), LIV);

    // Reset during CRASH with start held through reset release
    run_until("tmo_run3", P_RUN, 30, n);
    bus.colision = 1'b1;
    cycle();
    bus.colision = 1'b0;
    repeat (3) cycle();
    reset2 = 1'b0;
    bus.start_n = 1'b0;
    cycle();
    check("mid_rst_st", int'(bus.state), P_IDLE);
    check("mid_rst_lv", int'(bus.lives), LIV);
    check("mid_rst_cd", int'(bus.countdown), 0);
    cycle();
    reset2 = 1'b1;
    repeat (6) cycle();
    check("held_start", int'(bus.state), P_IDLE);
    bus.start_n = 1'b1;
    cycle();

`ifdef GAME_SEQ_PAUSE_EN
    // Pause in the middle of a second, collisions ignored while paused
    press_start();
    run_until("tmo_run4", P_RUN, 30, n);
    for (int i = 0; i < SEC + 1 && m_pos != 1; i++) cycle();
    bus.pause_n = 1'b0;
    cycle();
    cycle();
    check("pause_in", int'(bus.state), P_PAUSE);
    bus.colision = 1'b1;
    bus.start_n = 1'b0;
    repeat (20) cycle();
    check("pause_hold", int'(bus.state), P_PAUSE);
    bus.colision = 1'b0;
    bus.start_n = 1'b1;
    bus.pause_n = 1'b1;
    cycle();
    bus.pause_n = 1'b0;
    run_until("tmo_resume", P_RUN, 5, n);
    n = 0;
    while (bus.score_tick !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    check("resume_tick", n, 2);
    bus.pause_n = 1'b1;
    cycle();
`endif

    // Randomized pad and collision traffic
    for (int i = 0; i < 600; i++) begin
      reset2       = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      bus.start_n  = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      bus.colision = ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
      if ($urandom_range(0, 9) == 0) bus.pause_n = ~bus.pause_n;
`endif
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
